// File: rtl/dma_pkg.sv
// Shared constants and FSM state encoding for the DMA-side Wishbone memory responder.
package dma_pkg;
   localparam logic [31:0] BASE_ADDR = 32'h3800_0000;
   localparam logic [11:0] OFS_START = 12'h2B0;
   localparam logic [11:0] OFS_DONE  = 12'h2B4;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
endpackage

// File: rtl/dma_bram.sv
// Single-port word RAM with four byte-write enables and a registered read.
// Each byte lane is a separate array so the lanes infer cleanly as byte-enabled block RAM.
module dma_bram #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
         if (we[gi]) mem[addr] <= wdata[gi*8 +: 8];
         q_reg <= mem[addr];
      end

      assign rdata[gi*8 +: 8] = q_reg;
   end
endmodule

// File: rtl/wb_dma_mem_responder.sv
// Wishbone slave for the DMA initiator: byte-writable word memory with programmable ack wait,
// plus START/DONE control registers.
module wb_dma_mem_responder #(
   parameter logic [31:0] BASE_ADDR = dma_pkg::BASE_ADDR,
   parameter int          DEPTH     = 256,
   parameter int          ACK_DELAY = 3
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        dma_start_o,
   output logic        dma_done_o,
   output logic        busy_o
);
   import dma_pkg::*;

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [12:0] MEM_BYTES = 13'(DEPTH * 4);

   state_t      state;
   logic [3:0]  cnt_reg;
   logic [11:0] ofs_reg;
   logic [31:0] dat_reg;
   logic [3:0]  sel_reg;
   logic        we_reg;
   logic        mem_hit_reg;
   logic [31:0] reg_rdata_reg;
   logic        ack_reg;
   logic        start_reg;
   logic        done_reg;
   logic        busy_reg;

   logic [11:0]   ofs;
   logic          req;
   logic          reg_space;
   logic          mem_ok;
   logic [AW-1:0] ram_addr;
   logic [3:0]    ram_we;
   logic [31:0]   ram_q;

   assign ofs       = wbs_adr_i[11:0];
   assign req       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
   assign reg_space = (ofs >= OFS_START);
   assign mem_ok    = !reg_space && ({1'b0, ofs} < MEM_BYTES);

   // In IDLE the RAM looks at the live bus so a zero-wait read still has data in the ACK cycle.
   assign ram_addr = (state == IDLE) ? wbs_adr_i[AW+1:2] : ofs_reg[AW+1:2];
   assign ram_we   = (state == ACK && we_reg && mem_hit_reg) ? sel_reg : 4'b0000;

   dma_bram #(.DEPTH(DEPTH), .AW(AW)) u_bram (
      .clk   (wb_clk_i),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (dat_reg),
      .rdata (ram_q)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state         <= IDLE;
         cnt_reg       <= 4'd0;
         ofs_reg       <= 12'd0;
         dat_reg       <= 32'd0;
         sel_reg       <= 4'd0;
         we_reg        <= 1'b0;
         mem_hit_reg   <= 1'b0;
         reg_rdata_reg <= 32'd0;
         ack_reg       <= 1'b0;
         start_reg     <= 1'b0;
         done_reg      <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         ack_reg   <= 1'b0;
         start_reg <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  ofs_reg       <= ofs;
                  dat_reg       <= wbs_dat_i;
                  sel_reg       <= wbs_sel_i;
                  we_reg        <= wbs_we_i;
                  mem_hit_reg   <= mem_ok;
                  reg_rdata_reg <= (!wbs_we_i && ofs == OFS_DONE) ? {31'b0, done_reg} : 32'd0;
                  busy_reg      <= 1'b1;
                  if (!reg_space && ACK_DELAY != 0) begin
                     state   <= WAIT;
                     cnt_reg <= 4'(ACK_DELAY);
                  end else begin
                     state   <= ACK;
                     ack_reg <= 1'b1;
                     if (wbs_we_i && ofs == OFS_START && wbs_dat_i[0]) begin
                        start_reg <= 1'b1;
                        done_reg  <= 1'b0;
                     end
                  end
               end
            end
            WAIT: begin
               if (!(wbs_cyc_i && wbs_stb_i)) begin
                  state    <= IDLE;
                  cnt_reg  <= 4'd0;
                  busy_reg <= 1'b0;
               end else if (cnt_reg == 4'd1) begin
                  state   <= ACK;
                  cnt_reg <= 4'd0;
                  ack_reg <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            ACK: begin
               state    <= IDLE;
               busy_reg <= 1'b0;
               if (we_reg && ofs_reg == OFS_DONE) done_reg <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               busy_reg <= 1'b0;
            end
         endcase
      end
   end

   assign wbs_ack_o   = ack_reg;
   assign wbs_dat_o   = ack_reg ? (mem_hit_reg ? ram_q : reg_rdata_reg) : 32'd0;
   assign dma_start_o = start_reg;
   assign dma_done_o  = done_reg;
   assign busy_o      = busy_reg;
endmodule

// File: tb/tb_wb_dma_mem_responder.sv
// Directed bench for wb_dma_mem_responder: memory, byte enables, control registers, abort,
// out-of-window, back-to-back reads and reset mid-transfer.
module tb_wb_dma_mem_responder;
   logic        clk;
   logic        rst;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat;
   logic        ack;
   logic [31:0] dat_o;
   logic        start;
   logic        done;
   logic        busy;

   int errors;
   int checks;
   int start_pulses;
   logic start_at_ack;
   logic done_at_ack;

   localparam logic [31:0] A_START = 32'h3800_02B0;
   localparam logic [31:0] A_DONE  = 32'h3800_02B4;

   wb_dma_mem_responder dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .wbs_cyc_i   (cyc),
      .wbs_stb_i   (stb),
      .wbs_we_i    (we),
      .wbs_sel_i   (sel),
      .wbs_adr_i   (adr),
      .wbs_dat_i   (dat),
      .wbs_ack_o   (ack),
      .wbs_dat_o   (dat_o),
      .dma_start_o (start),
      .dma_done_o  (done),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial start_pulses = 0;
   always @(negedge clk) if (start === 1'b1) start_pulses++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   function automatic logic [31:0] pattern(input int i);
      return 32'hC0DE_0000 + 32'(i * 32'h0000_0111);
   endfunction

   // Starts and ends on a falling edge; leaves one idle cycle after the ack.
   task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic w, output logic [31:0] rd, output int lat);
      adr = a; dat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
      lat = 0;
      rd  = 32'hxxxx_xxxx;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         lat++;
         if (ack) break;
      end
      if (!ack) lat = 99;
      rd           = dat_o;
      start_at_ack = start;
      done_at_ack  = done;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      $display("xfer %s adr=0x%08h dat=0x%08h sel=%h rd=0x%08h lat=%0d",
               w ? "WR" : "RD", a, d, s, rd, lat);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rd;
      int lat;
      int p0;
      int n;
      int prev;
      int acks;
      int busies;
      int nonzero;

      errors = 0; checks = 0;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; dat = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_ack",   32'(ack),   32'd0);
      check("rst_dat",   dat_o,      32'd0);
      check("rst_start", 32'(start), 32'd0);
      check("rst_done",  32'(done),  32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1: full-word write then read
      xfer(32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, rd, lat);
      check("t1_wr_lat", 32'(lat), 32'd4);
      xfer(32'h3800_0010, 32'd0, 4'hF, 1'b0, rd, lat);
      check("t1_rd_lat", 32'(lat), 32'd4);
      check("t1_rd_dat", rd, 32'hDEAD_BEEF);

      // 2: byte enables, then sel=0 write leaves the word untouched
      xfer(32'h3800_0010, 32'h1122_3344, 4'b0101, 1'b1, rd, lat);
      xfer(32'h3800_0010, 32'd0, 4'hF, 1'b0, rd, lat);
      check("t2_sel_dat", rd, 32'hDE22_BE44);
      xfer(32'h3800_0010, 32'h0000_0000, 4'h0, 1'b1, rd, lat);
      check("t2_sel0_lat", 32'(lat), 32'd4);
      xfer(32'h3800_0010, 32'd0, 4'hF, 1'b0, rd, lat);
      check("t2_sel0_dat", rd, 32'hDE22_BE44);

      // 3: control registers
      xfer(A_DONE, 32'h1, 4'hF, 1'b1, rd, lat);
      check("t3_done_wr_lat", 32'(lat), 32'd1);
      check("t3_done_in_ack", 32'(done_at_ack), 32'd0);
      check("t3_done_after",  32'(done), 32'd1);
      p0 = start_pulses;
      xfer(A_START, 32'h1, 4'hF, 1'b1, rd, lat);
      check("t3_start_lat",     32'(lat), 32'd1);
      check("t3_start_in_ack",  32'(start_at_ack), 32'd1);
      check("t3_done_clr",      32'(done_at_ack), 32'd0);
      check("t3_start_pulses",  32'(start_pulses - p0), 32'd1);
      check("t3_done_after_st", 32'(done), 32'd0);
      xfer(A_DONE, 32'h1, 4'hF, 1'b1, rd, lat);
      check("t3_done_set", 32'(done), 32'd1);
      xfer(A_DONE, 32'd0, 4'hF, 1'b0, rd, lat);
      check("t3_done_rd", rd, 32'h1);
      xfer(A_START, 32'd0, 4'hF, 1'b0, rd, lat);
      check("t3_start_rd", rd, 32'h0);

      // out-of-memory offsets inside the window: direct ack, reads 0, writes dropped
      xfer(32'h3800_0000, 32'h0BAD_F00D, 4'hF, 1'b1, rd, lat);
      xfer(32'h3800_0400, 32'hFFFF_FFFF, 4'hF, 1'b1, rd, lat);
      check("oor_wr_lat", 32'(lat), 32'd1);
      xfer(32'h3800_0400, 32'd0, 4'hF, 1'b0, rd, lat);
      check("oor_rd_dat", rd, 32'd0);
      xfer(32'h3800_0000, 32'd0, 4'hF, 1'b0, rd, lat);
      check("oor_alias", rd, 32'h0BAD_F00D);

      // 4: abort by dropping cyc during WAIT
      xfer(32'h3800_0020, 32'h1234_5678, 4'hF, 1'b1, rd, lat);
      adr = 32'h3800_0020; dat = 32'hA5A5_A5A5; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      acks = 0;
      repeat (2) begin
         @(negedge clk);
         if (ack) acks++;
      end
      cyc = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ack) acks++;
      end
      stb = 1'b0; we = 1'b0;
      check("t4_abort_acks", 32'(acks), 32'd0);
      check("t4_abort_busy", 32'(busy), 32'd0);
      xfer(32'h3800_0020, 32'd0, 4'hF, 1'b0, rd, lat);
      check("t4_old_value", rd, 32'h1234_5678);

      // 5: outside the window
      adr = 32'h3000_0000; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      acks = 0; busies = 0; nonzero = 0;
      repeat (20) begin
         @(negedge clk);
         if (ack) acks++;
         if (busy) busies++;
         if (dat_o != 32'd0) nonzero++;
      end
      cyc = 1'b0; stb = 1'b0;
      check("t5_acks", 32'(acks), 32'd0);
      check("t5_busy", 32'(busies), 32'd0);
      check("t5_dat",  32'(nonzero), 32'd0);
      @(negedge clk);

      // 6: back-to-back reads with stb held high
      for (int i = 0; i < 11; i++)
         xfer(32'h3800_0100 + 32'(i * 4), pattern(i), 4'hF, 1'b1, rd, lat);
      adr = 32'h3800_0100; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      n = 0; prev = 0;
      for (int t = 0; t < 200 && n < 11; t++) begin
         @(negedge clk);
         if (ack) begin
            check($sformatf("t6_dat%0d", n), dat_o, pattern(n));
            if (n == 0) check("t6_first_lat", 32'(t + 1), 32'd4);
            else        check($sformatf("t6_space%0d", n), 32'(t - prev), 32'd5);
            $display("burst rd adr=0x%08h rd=0x%08h", adr, dat_o);
            prev = t;
            n++;
            adr = 32'h3800_0100 + 32'(n * 4);
         end
      end
      check("t6_count", 32'(n), 32'd11);
      repeat (2) @(negedge clk);
      check("t6_busy_wait", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_rst_ack",  32'(ack),  32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      xfer(32'h3800_0100, 32'd0, 4'hF, 1'b0, rd, lat);
      check("t6_mem_kept", rd, pattern(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
